// File: rtl/instr_fetch_loader.sv
// Loadable instruction-fetch stage: byte-stream program loader into a byte RAM,
// then registered little-endian 16-bit fetches with automatic halt after the last word.
module instr_fetch_loader #(
  parameter int MEM_BYTES = 32,
  parameter int PC_W      = $clog2(MEM_BYTES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            load_valid,
  input  logic [7:0]      load_byte,
  output logic            load_ready,
  input  logic            run,
  input  logic            stall,
  output logic [15:0]     instruction_code,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic [PC_W:0]   prog_len,
  output logic            halted
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [PC_W:0]   wr_ptr;
  logic [PC_W:0]   last_pc;
  logic            at_last;
  logic            wr_en;
  logic            can_run;
  logic [7:0]      mem [MEM_BYTES];

  assign load_ready = (state == S_LOAD) && (wr_ptr < (PC_W+1)'(MEM_BYTES));
  // a byte offered in the cycle load_en drops is discarded
  assign wr_en      = load_ready && load_valid && load_en;
  assign can_run    = prog_len >= (PC_W+1)'(2);
  // address of the last complete instruction; an odd trailing byte is skipped
  assign last_pc    = (prog_len & ~(PC_W+1)'(1)) - (PC_W+1)'(2);
  assign at_last    = ({1'b0, pc} == last_pc);
  assign halted     = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load_en)            state_nxt = S_LOAD;
        else if (run && can_run) state_nxt = S_RUN;
      end
      S_LOAD: if (!load_en) state_nxt = S_IDLE;
      S_RUN: begin
        if (!run)                state_nxt = S_IDLE;
        else if (!stall && at_last) state_nxt = S_HALT;
      end
      S_HALT: if (!run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc               <= '0;
      wr_ptr           <= '0;
      prog_len         <= '0;
      instruction_code <= 16'h0000;
      instr_valid      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_en)             wr_ptr <= '0;
          else if (run && can_run) pc     <= '0;
        end
        S_LOAD: begin
          if (!load_en)   prog_len <= wr_ptr;
          else if (wr_en) wr_ptr   <= wr_ptr + (PC_W+1)'(1);
        end
        S_RUN: begin
          if (!run) begin
            instr_valid <= 1'b0;
          end else if (!stall) begin
            instruction_code <= {mem[{pc[PC_W-1:1], 1'b1}], mem[pc]};
            instr_valid      <= 1'b1;
            pc               <= pc + PC_W'(2);
          end
        end
        S_HALT: begin
          if (!run) begin
            instr_valid <= 1'b0;
            pc          <= '0;
          end else if (!stall) begin
            instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PC_W-1:0]] <= load_byte;
  end

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Bench for instr_fetch_loader: vector table, hand corner sequences and
// randomized load/run/stall checked against a word-list model of the program.
module tb_instr_fetch_loader;
  localparam int MEM_BYTES = 32;
  localparam int PC_W      = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_en = 1'b0, load_valid = 1'b0, run = 1'b0, stall = 1'b0;
  logic [7:0]      load_byte = 8'h00;
  logic            load_ready, instr_valid, halted;
  logic [15:0]     instruction_code;
  logic [PC_W-1:0] pc;
  logic [PC_W:0]   prog_len;

  instr_fetch_loader #(.MEM_BYTES(MEM_BYTES), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(load_ready), .run(run), .stall(stall),
    .instruction_code(instruction_code), .instr_valid(instr_valid), .pc(pc),
    .prog_len(prog_len), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];

  typedef struct {
    int          n;
    logic [7:0]  b [8];
    int          exp_len;
    int          exp_cnt;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: bytes past the RAM depth are dropped, words are consecutive byte pairs.
  function automatic int model_len(bq_t b);
    return (b.size() > MEM_BYTES) ? MEM_BYTES : b.size();
  endfunction

  function automatic wq_t model_words(bq_t b);
    wq_t w = {};
    for (int i = 0; i < model_len(b) / 2; i++) w.push_back({b[2*i+1], b[2*i]});
    return w;
  endfunction

  task automatic load_prog(input bq_t b, input bit gaps);
    @(negedge clk);
    load_en = 1; run = 0; stall = 0; load_valid = 0;
    @(negedge clk);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        load_valid = 0;
        @(negedge clk);
      end
      load_valid = 1;
      load_byte  = b[i];
      chk($sformatf("load_ready[%0d]", i), load_ready, (i < MEM_BYTES));
      @(negedge clk);
    end
    load_valid = 0; load_en = 0;
    @(negedge clk);
    chk("prog_len", prog_len, model_len(b));
  endtask

  task automatic run_prog(input int stall_pct, input int exp_cnt, output wq_t got, output int halt_at);
    bit prev_halt, done;
    int cyc;
    got = {}; halt_at = -1; done = 0; cyc = 0;
    run = 1; stall = 0;
    @(negedge clk);
    while (!done && cyc < 400) begin
      prev_halt = halted;
      stall = ($urandom_range(0, 99) < stall_pct);
      @(negedge clk);
      cyc++;
      if (stall) begin
        if (got.size() > 0) chk("stall_hold_code", instruction_code, got[$]);
      end else if (prev_halt) begin
        chk("valid_after_halt", instr_valid, 0);
        done = 1;
      end else if (instr_valid) begin
        got.push_back(instruction_code);
        chk("pc_after_fetch", pc, (2 * got.size()) % MEM_BYTES);
        if (halted && halt_at < 0) halt_at = got.size();
      end
      if (exp_cnt == 0 && cyc >= 10) done = 1;
    end
    if (!done) chk("run_timeout", 0, 1);
    stall = 0; run = 0;
    @(negedge clk);
    chk("halted_cleared", halted, 0);
    chk("valid_cleared", instr_valid, 0);
  endtask

  task automatic cmp_run(input string tag, input bq_t b, input int stall_pct);
    wq_t exp, got;
    int  halt_at;
    exp = model_words(b);
    run_prog(stall_pct, exp.size(), got, halt_at);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_word[%0d]", tag, i), got[i], exp[i]);
    if (exp.size() > 0) chk({tag, "_halt_at"}, halt_at, exp.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    bq_t  b;
    wq_t  got;
    int   halt_at;

    tbl[0] = '{n:4, b:'{8'h03,8'h05,8'h0B,8'h05,8'h00,8'h00,8'h00,8'h00}, exp_len:4, exp_cnt:2, exp_first:16'h0503, exp_last:16'h050B};
    tbl[1] = '{n:5, b:'{8'h11,8'h22,8'h33,8'h44,8'h55,8'h00,8'h00,8'h00}, exp_len:5, exp_cnt:2, exp_first:16'h2211, exp_last:16'h4433};
    tbl[2] = '{n:2, b:'{8'hAA,8'hBB,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_len:2, exp_cnt:1, exp_first:16'hBBAA, exp_last:16'hBBAA};
    tbl[3] = '{n:1, b:'{8'h7E,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_len:1, exp_cnt:0, exp_first:16'h0000, exp_last:16'h0000};
    tbl[4] = '{n:0, b:'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_len:0, exp_cnt:0, exp_first:16'h0000, exp_last:16'h0000};
    tbl[5] = '{n:8, b:'{8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08}, exp_len:8, exp_cnt:4, exp_first:16'h0201, exp_last:16'h0807};
    tbl[6] = '{n:3, b:'{8'hC0,8'hFF,8'hEE,8'h00,8'h00,8'h00,8'h00,8'h00}, exp_len:3, exp_cnt:1, exp_first:16'hFFC0, exp_last:16'hFFC0};

    // reset state
    #12;
    chk("rst_valid", instr_valid, 0);
    chk("rst_code", instruction_code, 0);
    chk("rst_pc", pc, 0);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_halted", halted, 0);
    chk("rst_load_ready", load_ready, 0);
    @(negedge clk);
    rst_n = 1;

    // run with empty program stays idle; load_en wins over run
    run = 1;
    repeat (3) begin
      @(negedge clk);
      chk("empty_run_valid", instr_valid, 0);
      chk("empty_run_halted", halted, 0);
      chk("empty_run_ready", load_ready, 0);
    end
    load_en = 1;
    @(negedge clk);
    chk("load_priority_ready", load_ready, 1);
    load_en = 0; run = 0;
    @(negedge clk);
    chk("load_priority_len", prog_len, 0);

    // vector table
    foreach (tbl[t]) begin
      b = {};
      for (int i = 0; i < tbl[t].n; i++) b.push_back(tbl[t].b[i]);
      load_prog(b, 0);
      chk($sformatf("tbl%0d_len", t), prog_len, tbl[t].exp_len);
      run_prog(0, tbl[t].exp_cnt, got, halt_at);
      chk($sformatf("tbl%0d_cnt", t), got.size(), tbl[t].exp_cnt);
      if (tbl[t].exp_cnt > 0 && got.size() > 0) begin
        chk($sformatf("tbl%0d_first", t), got[0], tbl[t].exp_first);
        chk($sformatf("tbl%0d_last", t), got[$], tbl[t].exp_last);
        chk($sformatf("tbl%0d_halt_at", t), halt_at, tbl[t].exp_cnt);
      end
    end

    // overfill: 33rd byte dropped, 16 instructions
    b = {};
    for (int i = 0; i < 33; i++) b.push_back(8'($urandom));
    load_prog(b, 0);
    chk("full_len", prog_len, 32);
    cmp_run("full", b, 0);

    // stall during the second fetch freezes pc and code
    b = {};
    for (int i = 0; i < 8; i++) b.push_back(8'(8'h10 + i));
    load_prog(b, 0);
    run = 1;
    @(negedge clk);
    @(negedge clk);
    chk("st_code1", instruction_code, 16'h1110);
    chk("st_pc1", pc, 2);
    @(negedge clk);
    chk("st_code2", instruction_code, 16'h1312);
    stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("st_hold_code", instruction_code, 16'h1312);
      chk("st_hold_pc", pc, 4);
      chk("st_hold_valid", instr_valid, 1);
    end
    stall = 0;
    @(negedge clk);
    chk("st_code3", instruction_code, 16'h1514);
    chk("st_pc3", pc, 6);
    @(negedge clk);
    chk("st_code4", instruction_code, 16'h1716);
    chk("st_halted", halted, 1);
    @(negedge clk);
    chk("st_valid_end", instr_valid, 0);
    run = 0;
    @(negedge clk);

    // reset mid-run
    load_prog(b, 0);
    run = 1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mr_valid", instr_valid, 0);
    chk("mr_code", instruction_code, 0);
    chk("mr_pc", pc, 0);
    chk("mr_len", prog_len, 0);
    chk("mr_halted", halted, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("mr_run_valid", instr_valid, 0);
      chk("mr_run_pc", pc, 0);
      chk("mr_run_halted", halted, 0);
    end
    run = 0;
    @(negedge clk);

    // randomized programs, gaps and stalls
    for (int r = 0; r < 8; r++) begin
      b = {};
      for (int i = 0; i < int'($urandom_range(0, 36)); i++) b.push_back(8'($urandom));
      load_prog(b, 1);
      cmp_run($sformatf("rnd%0d", r), b, 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
